key_event_decoder: RTL

- Consumes the clean, debounced key level produced by the board-key debouncer and converts it into single-cycle key events: press, release, short press, long press, auto-repeat and double click.
- Sits between the debouncer output and the menu/control FSMs, so downstream logic never handles raw levels or timing.
- Timing counts a shared slow strobe (tick_en, e.g. 1 kHz), which keeps the counters narrow.

---
 rtl/key_event_decoder.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/key_event_decoder.sv
// Turns a debounced key level into single-cycle events: press, release, short, long,
// auto-repeat and double click. All timing is counted in tick_en strobes.
module key_event_decoder #(
    parameter logic        PRESSED_LEVEL = 1'b0,
    parameter logic [15:0] LONG_TICKS    = 16'd800,
    parameter logic [15:0] REPEAT_TICKS  = 16'd100,
    parameter logic [15:0] DCLICK_TICKS  = 16'd250
) (
    input  logic clk,
    input  logic reset_n,
    input  logic tick_en,
    input  logic key_lvl,
    output logic press_pulse,
    output logic release_pulse,
    output logic short_press,
    output logic long_press,
    output logic repeat_pulse,
    output logic double_click,
    output logic held
);

    typedef enum logic [2:0] {
        StArm      = 3'd0,
        StIdle     = 3'd1,
        StPressed  = 3'd2,
        StLong     = 3'd3,
        StWait2    = 3'd4,
        StPressed2 = 3'd5
    } state_e;

    state_e      state_q;
    logic [15:0] cnt_q;

    logic pressed;
    logic long_hit;
    logic repeat_hit;
    logic dclick_hit;

    assign pressed    = (key_lvl == PRESSED_LEVEL);
    assign long_hit   = tick_en && (cnt_q == LONG_TICKS - 16'd1);
    assign repeat_hit = tick_en && (cnt_q == REPEAT_TICKS - 16'd1);
    assign dclick_hit = tick_en && (cnt_q == DCLICK_TICKS - 16'd1);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q       <= StArm;
            cnt_q         <= '0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            short_press   <= 1'b0;
            long_press    <= 1'b0;
            repeat_pulse  <= 1'b0;
            double_click  <= 1'b0;
            held          <= 1'b0;
        end else begin
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            short_press   <= 1'b0;
            long_press    <= 1'b0;
            repeat_pulse  <= 1'b0;
            double_click  <= 1'b0;
            if (tick_en) begin
                cnt_q <= cnt_q + 16'd1;
            end

            // Key edges are tested before tick conditions so an edge wins a same-cycle tick.
            unique case (state_q)
                StArm: begin
                    if (!pressed) begin
                        state_q <= StIdle;
                        cnt_q   <= '0;
                    end
                end
                StIdle: begin
                    if (pressed) begin
                        state_q     <= StPressed;
                        cnt_q       <= '0;
                        press_pulse <= 1'b1;
                        held        <= 1'b1;
                    end
                end
                StPressed: begin
                    if (!pressed) begin
                        cnt_q         <= '0;
                        release_pulse <= 1'b1;
                        held          <= 1'b0;
                        if (DCLICK_TICKS == 16'd0) begin
                            state_q     <= StIdle;
                            short_press <= 1'b1;
                        end else begin
                            state_q <= StWait2;
                        end
                    end else if (long_hit) begin
                        state_q    <= StLong;
                        cnt_q      <= '0;
                        long_press <= 1'b1;
                    end
                end
                StLong: begin
                    if (!pressed) begin
                        state_q       <= StIdle;
                        cnt_q         <= '0;
                        release_pulse <= 1'b1;
                        held          <= 1'b0;
                    end else if (repeat_hit) begin
                        cnt_q        <= '0;
                        repeat_pulse <= 1'b1;
                    end
                end
                StWait2: begin
                    if (pressed) begin
                        state_q     <= StPressed2;
                        cnt_q       <= '0;
                        press_pulse <= 1'b1;
                        held        <= 1'b1;
                    end else if (dclick_hit) begin
                        state_q     <= StIdle;
                        cnt_q       <= '0;
                        short_press <= 1'b1;
                    end
                end
                StPressed2: begin
                    if (!pressed) begin
                        state_q       <= StIdle;
                        cnt_q         <= '0;
                        release_pulse <= 1'b1;
                        double_click  <= 1'b1;
                        held          <= 1'b0;
                    end else if (long_hit) begin
                        state_q    <= StLong;
                        cnt_q      <= '0;
                        long_press <= 1'b1;
                    end
                end
                default: begin
                    state_q <= StArm;
                    cnt_q   <= '0;
                    held    <= 1'b0;
                end
            endcase
        end
    end

endmodule
